// File: rtl/gate_response_checker_if.sv
// Bundles the checker's control, status and gate-under-test signals.
//   start, op           : sweep request and gate select (environment -> checker)
//   Y                   : gate-under-test output (gate -> checker)
//   A, B                : gate-under-test inputs (checker -> gate)
//   busy, done, pass    : sweep status
//   err_count, fail_mask: mismatch count and per-vector failure bits
//   bad_op              : illegal gate select latched at start
interface gate_response_checker_if;
    logic       start;
    logic [2:0] op;
    logic       Y;
    logic       A;
    logic       B;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_mask;
    logic       bad_op;

    modport master (
        input  start, op, Y,
        output A, B, busy, done, pass, err_count, fail_mask, bad_op
    );

    modport slave (
        output start, op, Y,
        input  A, B, busy, done, pass, err_count, fail_mask, bad_op
    );
endinterface

// File: rtl/gate_response_checker.sv
// Stimulus/response checker for a two-input logic gate. Drives A/B through
// 00, 01, 10, 11, holding each vector HOLD_CYCLES cycles, samples Y on the last
// edge of each window and compares it with the truth table of the gate
// selected by op. Reports per-vector failures, an error count and pass/done.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   gif   : control, status and gate-under-test signals (master side)
//
// state   | meaning
// IDLE    | waiting for start after reset
// RUN     | sweeping the four vectors
// DONE    | sweep finished (or illegal op); results held until next start
module gate_response_checker #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    gate_response_checker_if.master        gif
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] op_q, op_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] mask_q, mask_d;
    logic       bad_q, bad_d;
    logic       mismatch;

    function automatic logic expected_y(input logic [2:0] sel, input logic a, input logic b);
        case (sel)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        mask_d   = mask_q;
        bad_d    = bad_q;
        mismatch = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (gif.start) begin
                    op_d   = gif.op;
                    err_d  = 3'd0;
                    mask_d = 4'd0;
                    pass_d = 1'b0;
                    idx_d  = 2'd0;
                    hold_d = 8'd0;
                    a_d    = 1'b0;
                    b_d    = 1'b0;
                    if (gif.op > 3'd5) begin
                        // Illegal select: report immediately, never drive the gate.
                        state_d = ST_DONE;
                        bad_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                        bad_d   = 1'b0;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (hold_q < HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end else begin
                    // Y is combinational from the registered A/B, so it has
                    // settled by the last edge of the hold window.
                    mismatch = (gif.Y != expected_y(op_q, a_q, b_q));
                    if (mismatch) begin
                        mask_d[idx_q] = 1'b1;
                        err_d         = err_q + 3'd1;
                    end
                    if (idx_q != 2'd3) begin
                        idx_d  = idx_q + 2'd1;
                        a_d    = idx_d[1];
                        b_d    = idx_d[0];
                        hold_d = 8'd0;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 3'd0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            hold_q  <= 8'd0;
            op_q    <= 3'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            mask_q  <= 4'd0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            bad_q   <= bad_d;
        end
    end

    assign gif.A         = a_q;
    assign gif.B         = b_q;
    assign gif.busy      = busy_q;
    assign gif.done      = done_q;
    assign gif.pass      = pass_q;
    assign gif.err_count = err_q;
    assign gif.fail_mask = mask_q;
    assign gif.bad_op    = bad_q;
endmodule

// File: tb/tb_gate_response_checker.sv
// Testbench for gate_response_checker. Two instances: HOLD_CYCLES=4 and
// HOLD_CYCLES=1. A bench-level model predicts every output from elapsed time
// since the accepted start; literal expectations pin the key sweeps.
module tb_gate_response_checker;
    localparam int H0 = 4;
    localparam int H1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gate_response_checker_if ifc0 ();
    gate_response_checker_if ifc1 ();

    gate_response_checker #(.HOLD_CYCLES(H0)) dut0 (.clk(clk), .rst_n(rst_n), .gif(ifc0));
    gate_response_checker #(.HOLD_CYCLES(H1)) dut1 (.clk(clk), .rst_n(rst_n), .gif(ifc1));

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Gate generator select: 0 AND,1 OR,2 NAND,3 NOR,4 XOR,5 XNOR,6 stuck-at-0
    int ymode0 = 0;
    int ymode1 = 0;

    function automatic logic gate(input int g, input logic a, input logic b);
        case (g)
            0: return a & b;
            1: return a | b;
            2: return ~(a & b);
            3: return ~(a | b);
            4: return a ^ b;
            5: return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    assign ifc0.Y = gate(ymode0, ifc0.A, ifc0.B);
    assign ifc1.Y = gate(ymode1, ifc1.A, ifc1.B);

    // Truth tables, bit i = expected Y for vector i (A=i[1], B=i[0]).
    function automatic logic [3:0] tbl(input int g);
        case (g)
            0: return 4'b1000;
            1: return 4'b1110;
            2: return 4'b0111;
            3: return 4'b0001;
            4: return 4'b0110;
            5: return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    // Model: phase 0 idle/reset, 1 running, 2 done, 3 illegal op
    int   ph[2];
    int   tm[2];
    int   mop[2];
    int   mgen[2];
    int   hold[2] = '{H0, H1};

    task automatic model_step(input int d, input logic st, input logic [2:0] o, input int gen);
        if (!rst_n) begin
            ph[d] = 0;
        end else if (ph[d] == 1) begin
            tm[d]++;
            if (tm[d] == 4 * hold[d]) ph[d] = 2;
        end else if (st) begin
            mop[d]  = int'(o);
            mgen[d] = gen;
            if (o > 3'd5) ph[d] = 3;
            else begin
                ph[d] = 1;
                tm[d] = 0;
            end
        end
    endtask

    // Packed order: {A,B,busy,done,pass,err_count[2:0],fail_mask[3:0],bad_op}
    function automatic logic [12:0] model_out(input int d);
        logic [3:0] mis, m;
        int v, e;
        mis = tbl(mop[d]) ^ tbl(mgen[d]);
        case (ph[d])
            1: begin
                v = tm[d] / hold[d];
                m = mis & 4'((1 << v) - 1);
                e = $countones(m);
                return {v[1], v[0], 1'b1, 1'b0, 1'b0, 3'(e), m, 1'b0};
            end
            2: begin
                m = mis;
                e = $countones(m);
                return {1'b1, 1'b1, 1'b0, 1'b1, (e == 0), 3'(e), m, 1'b0};
            end
            3: return 13'b0_0_0_1_0_000_0000_1;
            default: return 13'd0;
        endcase
    endfunction

    logic [12:0] out0, out1;
    assign out0 = {ifc0.A, ifc0.B, ifc0.busy, ifc0.done, ifc0.pass, ifc0.err_count, ifc0.fail_mask, ifc0.bad_op};
    assign out1 = {ifc1.A, ifc1.B, ifc1.busy, ifc1.done, ifc1.pass, ifc1.err_count, ifc1.fail_mask, ifc1.bad_op};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        ph = '{0, 0};
        tm = '{0, 0};
        mop = '{0, 0};
        mgen = '{0, 0};
    end

    always @(posedge clk) begin
        model_step(0, ifc0.start, ifc0.op, ymode0);
        model_step(1, ifc1.start, ifc1.op, ymode1);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("outs_dut0", 16'(out0), 16'(model_out(0)));
            chk("outs_dut1", 16'(out1), 16'(model_out(1)));
        end
    end

    task automatic sweep0(input int gen, input logic [2:0] opv, output int cyc, output int busyc);
        @(negedge clk);
        ymode0     = gen;
        ifc0.op    = opv;
        ifc0.start = 1'b1;
        @(negedge clk);
        ifc0.start = 1'b0;
        ifc0.op    = ~opv;
        cyc   = 0;
        busyc = 0;
        while (!ifc0.done && cyc < 200) begin
            if (ifc0.busy) busyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc, busyc, w;

    initial begin
        rst_n      = 1'b0;
        ifc0.start = 1'b0;
        ifc0.op    = 3'd0;
        ifc1.start = 1'b0;
        ifc1.op    = 3'd0;
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_outs", 16'(out0), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct NOR gate
        sweep0(3, 3'd3, cyc, busyc);
        chk("nor_done_latency", 16'(cyc), 16'd16);
        chk("nor_busy_cycles", 16'(busyc), 16'd16);
        chk("nor_pass", 16'(ifc0.pass), 16'd1);
        chk("nor_err", 16'(ifc0.err_count), 16'd0);
        chk("nor_mask", 16'(ifc0.fail_mask), 16'h0);

        // OR gate checked as NOR: every vector fails
        sweep0(1, 3'd3, cyc, busyc);
        chk("or_as_nor_err", 16'(ifc0.err_count), 16'd4);
        chk("or_as_nor_mask", 16'(ifc0.fail_mask), 16'hf);
        chk("or_as_nor_pass", 16'(ifc0.pass), 16'd0);

        // Stuck-at-0 output
        sweep0(6, 3'd3, cyc, busyc);
        chk("stuck_nor_mask", 16'(ifc0.fail_mask), 16'h1);
        chk("stuck_nor_err", 16'(ifc0.err_count), 16'd1);
        chk("stuck_nor_pass", 16'(ifc0.pass), 16'd0);
        sweep0(6, 3'd0, cyc, busyc);
        chk("stuck_and_mask", 16'(ifc0.fail_mask), 16'h8);
        chk("stuck_and_err", 16'(ifc0.err_count), 16'd1);

        // Illegal op: done next cycle, A/B cleared from the previous 11
        @(negedge clk);
        ifc0.op    = 3'd7;
        ifc0.start = 1'b1;
        @(negedge clk);
        ifc0.start = 1'b0;
        chk("bad_op_outs", 16'(out0), 16'h0201);
        repeat (3) @(negedge clk);

        // Reset in the middle of vector 2 (A=1,B=0)
        @(negedge clk);
        ymode0     = 3;
        ifc0.op    = 3'd3;
        ifc0.start = 1'b1;
        @(negedge clk);
        ifc0.start = 1'b0;
        w = 0;
        while (!(ifc0.A == 1'b1 && ifc0.B == 1'b0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("reach_idx2", 16'(w), 16'd8);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_reset_outs", 16'(out0), 16'd0);
        sweep0(3, 3'd3, cyc, busyc);
        chk("post_reset_latency", 16'(cyc), 16'd16);
        chk("post_reset_busy", 16'(busyc), 16'd16);
        chk("post_reset_pass", 16'(ifc0.pass), 16'd1);

        // HOLD_CYCLES=1, XOR, start held high: back-to-back sweeps
        @(negedge clk);
        ymode1     = 4;
        ifc1.op    = 3'd4;
        ifc1.start = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("h1_restart_busy", 16'({ifc1.busy, ifc1.done}), 16'b10);
            cyc = 0;
            while (!ifc1.done && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            chk("h1_done_latency", 16'(cyc), 16'd4);
            chk("h1_pass", 16'(ifc1.pass), 16'd1);
        end
        ifc1.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("h1_stays_done", 16'({ifc1.busy, ifc1.done}), 16'b01);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
